// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code monitor: FSM states, index width
// derivation and the canonical index -> code mapping.
package johnson_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int JW_MAX = 64;

  function automatic int idxw(input int w);
    return $clog2(2 * w);
  endfunction

  // Index k < w has its low k bits set; k >= w has its high 2w-k bits set.
  function automatic logic [JW_MAX-1:0] johnson_code(input int idx, input int w);
    logic [JW_MAX-1:0] c;
    c = '0;
    for (int i = 0; i < JW_MAX; i++) begin
      if (i < w) c[i] = (idx < w) ? (i < idx) : (i >= idx - w);
    end
    return c;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson decoder: flags whether the code is one of the 2*WIDTH
// legal patterns and returns its index.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDXW  = idxw(WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IDXW-1:0]  idx_o
);

  always_comb begin
    legal_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (JW_MAX'(code_i) == johnson_code(k, WIDTH)) begin
        legal_o = 1'b1;
        idx_o   = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_monitor.sv
// Johnson-code bus checker and binary converter with direction, wrap and error
// tracking. Optional hold/stall detection is enabled with STALL_DETECT_EN.
module johnson_monitor
  import johnson_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  int CNT_W        = 8,
  parameter  int STALL_CYCLES = 16,
  localparam int IDXW         = idxw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code,
  output logic [IDXW-1:0]  value,
  output logic             legal,
  output logic             dir_up,
  output logic             dir_down,
  output logic             wrap,
  output logic             step_err,
`ifdef STALL_DETECT_EN
  output logic             stall,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * WIDTH - 1);

  if (WIDTH < 2 || STALL_CYCLES < 1) begin : g_bad_param
    $error("johnson_monitor: WIDTH must be >= 2 and STALL_CYCLES >= 1");
  end

  logic            dec_legal;
  logic [IDXW-1:0] dec_idx;

  johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
    .code_i  (code),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  state_e          state_q, state_d;
  logic [IDXW-1:0] prev_q, prev_d;
  logic            legal_q, legal_d;
  logic            up_q, up_d;
  logic            dn_q, dn_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_up, idx_dn;

  assign idx_up = (prev_q == LAST_IDX) ? '0 : prev_q + IDXW'(1);
  assign idx_dn = (prev_q == '0) ? LAST_IDX : prev_q - IDXW'(1);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    legal_d = dec_legal;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      TRACK: begin
        if (dec_legal) begin
          prev_d = dec_idx;
          if (dec_idx != prev_q) begin
            if (dec_idx == idx_up) begin
              up_d   = 1'b1;
              wrap_d = (prev_q == LAST_IDX);
            end else if (dec_idx == idx_dn) begin
              dn_d   = 1'b1;
              wrap_d = (prev_q == '0);
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          err_d   = 1'b1;
          state_d = FAULT;
        end
      end
      // ACQ and FAULT both (re)acquire on the first legal code without a step pulse.
      ACQ, FAULT: begin
        if (dec_legal) begin
          state_d = TRACK;
          prev_d  = dec_idx;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  assign cnt_d = (err_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACQ;
      prev_q  <= '0;
      legal_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      legal_q <= legal_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value    = prev_q;
  assign legal    = legal_q;
  assign dir_up   = up_q;
  assign dir_down = dn_q;
  assign wrap     = wrap_q;
  assign step_err = err_q;
  assign err_cnt  = cnt_q;

`ifdef STALL_DETECT_EN
  localparam int              HW       = $clog2(STALL_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_SAT = HW'(STALL_CYCLES - 1);

  logic          hold_c;
  logic [HW-1:0] hold_q, hold_d;
  logic          stall_q;

  // Counter saturates at the threshold; it only needs to know "reached".
  assign hold_c = (state_q == TRACK) && dec_legal && (dec_idx == prev_q);
  assign hold_d = !hold_c ? '0 : (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      stall_q <= (hold_d >= HOLD_SAT);
    end
  end

  assign stall = stall_q;
`endif

endmodule

// File: tb/tb_johnson_monitor.sv
// Self-checking bench: directed scenarios plus a random walk, checked every
// cycle against a behavioural model of the monitor.
module tb_johnson_monitor;
  import johnson_pkg::*;

  localparam int W  = 4;
  localparam int N  = 2 * W;
  localparam int IW = 3;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  code = '0;

  logic [IW-1:0] value, s_value;
  logic          legal, dir_up, dir_down, wrap, step_err;
  logic          s_legal, s_dir_up, s_dir_down, s_wrap, s_step_err;
  logic [7:0]    err_cnt;
  logic [1:0]    s_err_cnt;
`ifdef STALL_DETECT_EN
  logic          stall, s_stall;
`endif

  johnson_monitor #(.WIDTH(W), .CNT_W(8), .STALL_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .code(code), .value(value), .legal(legal),
    .dir_up(dir_up), .dir_down(dir_down), .wrap(wrap), .step_err(step_err),
`ifdef STALL_DETECT_EN
    .stall(stall),
`endif
    .err_cnt(err_cnt)
  );

  johnson_monitor #(.WIDTH(W), .CNT_W(2), .STALL_CYCLES(SC)) dut_s (
    .clk(clk), .reset(reset), .code(code), .value(s_value), .legal(s_legal),
    .dir_up(s_dir_up), .dir_down(s_dir_down), .wrap(s_wrap), .step_err(s_step_err),
`ifdef STALL_DETECT_EN
    .stall(s_stall),
`endif
    .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] jc(input int k);
    logic [JW_MAX-1:0] t;
    t = johnson_code(k, W);
    return t[W-1:0];
  endfunction

  // Decode by shape: k ones packed at the bottom, or k ones packed at the top.
  function automatic int mdec(input logic [W-1:0] c);
    int n;
    int full;
    n = $countones(c);
    full = (1 << W) - 1;
    if (int'(c) == (1 << n) - 1) return n;
    if (n > 0 && int'(c) == (full & ~((1 << (W - n)) - 1))) return N - n;
    return -1;
  endfunction

  // Behavioural model: mode 0 = acquiring, 1 = tracking, 2 = faulted.
  int m_mode, m_prev, m_cnt, m_cnt2, m_hold;
  bit m_lg, m_up, m_dn, m_wr, m_err, m_stall, m_valid = 0;

  always @(posedge clk) begin
    int ix;
    int d;
    if (reset) begin
      m_mode = 0; m_prev = 0; m_cnt = 0; m_cnt2 = 0; m_hold = 0;
      m_lg = 0; m_up = 0; m_dn = 0; m_wr = 0; m_err = 0; m_stall = 0;
      m_valid = 1;
    end else begin
      ix = mdec(code);
      m_lg = (ix >= 0);
      m_up = 0; m_dn = 0; m_wr = 0; m_err = 0;
      d = m_lg ? (ix - m_prev + N) % N : -1;
      if (m_mode == 1 && d == 0) m_hold++;
      else m_hold = 0;
      if (!m_lg) begin
        m_err = 1;
        if (m_mode == 1) m_mode = 2;
      end else if (m_mode != 1) begin
        m_mode = 1;
        m_prev = ix;
      end else begin
        if (d == 1) begin m_up = 1; m_wr = (m_prev == N - 1); end
        else if (d == N - 1) begin m_dn = 1; m_wr = (m_prev == 0); end
        else if (d != 0) m_err = 1;
        m_prev = ix;
      end
      if (m_err) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_stall = (m_hold >= SC - 1);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("value", int'(value), m_prev);
      chk("legal", int'(legal), int'(m_lg));
      chk("dir_up", int'(dir_up), int'(m_up));
      chk("dir_down", int'(dir_down), int'(m_dn));
      chk("wrap", int'(wrap), int'(m_wr));
      chk("step_err", int'(step_err), int'(m_err));
      chk("err_cnt", int'(err_cnt), m_cnt);
      chk("err_cnt_sat2", int'(s_err_cnt), m_cnt2);
`ifdef STALL_DETECT_EN
      chk("stall", int'(stall), int'(m_stall));
`endif
    end
  end

  task automatic drive(input logic [W-1:0] c, input logic r);
    code = c;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    int r;
    drive('0, 1'b1);
    chk("rst_value", int'(value), 0);
    chk("rst_legal", int'(legal), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    drive('0, 1'b1);

    // Downward walk with one wrap.
    for (int i = 0; i <= N; i++) begin
      drive(jc((N - i) % N), 1'b0);
      chk("t1_value", int'(value), (N - i) % N);
      chk("t1_dir_down", int'(dir_down), (i > 0) ? 1 : 0);
      chk("t1_wrap", int'(wrap), (i == 1) ? 1 : 0);
    end
    chk("t1_err_cnt", int'(err_cnt), 0);

    // Upward walk, wrapping 7 -> 0.
    for (int i = 1; i <= N; i++) begin
      drive(jc(i % N), 1'b0);
      chk("t2_value", int'(value), i % N);
      chk("t2_dir_up", int'(dir_up), 1);
      chk("t2_wrap", int'(wrap), (i == N) ? 1 : 0);
    end

    // Illegal code then recovery.
    drive('0, 1'b1);
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0101, 1'b0);
    chk("t3_step_err", int'(step_err), 1);
    chk("t3_legal", int'(legal), 0);
    chk("t3_value", int'(value), 2);
    chk("t3_err_cnt", int'(err_cnt), 1);
    drive(4'b0111, 1'b0);
    chk("t3_value_rec", int'(value), 3);
    chk("t3_legal_rec", int'(legal), 1);
    chk("t3_no_dir", int'(dir_up | dir_down), 0);

    // Legal non-adjacent jump.
    drive(4'b0011, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b1110, 1'b0);
    chk("t4_step_err", int'(step_err), 1);
    chk("t4_err_cnt", int'(err_cnt), 2);
    chk("t4_value", int'(value), 5);
    chk("t4_no_dir", int'(dir_up | dir_down), 0);
    drive(4'b1100, 1'b0);
    chk("t4_dir_up", int'(dir_up), 1);
    chk("t4_value2", int'(value), 6);

    // Saturation of the narrow counter, then reset mid-stream.
    drive('0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      drive(4'b1010, 1'b0);
      chk("t5_sat_cnt", int'(s_err_cnt), (i < 3) ? i : 3);
      chk("t5_cnt", int'(err_cnt), i);
    end
    drive(4'b1010, 1'b1);
    chk("t5_rst_cnt", int'(err_cnt), 0);
    chk("t5_rst_err", int'(step_err), 0);
    chk("t5_rst_value", int'(value), 0);

    // Long hold followed by a down step.
    drive('0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive(4'b1100, 1'b0);
`ifdef STALL_DETECT_EN
      chk("t6_stall", int'(stall), (i >= SC) ? 1 : 0);
`endif
    end
    drive(4'b1110, 1'b0);
    chk("t6_dir_down", int'(dir_down), 1);
    chk("t6_value", int'(value), 5);
`ifdef STALL_DETECT_EN
    chk("t6_stall_off", int'(stall), 0);
`endif

    // Random walk with holds, jumps, junk codes and occasional reset.
    cur = 5;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        drive(jc(cur), 1'b1);
      end else if (r < 15) begin
        drive(W'($urandom), 1'b0);
      end else if (r < 40) begin
        drive(jc(cur), 1'b0);
      end else if (r < 62) begin
        cur = (cur + 1) % N;
        drive(jc(cur), 1'b0);
      end else if (r < 84) begin
        cur = (cur + N - 1) % N;
        drive(jc(cur), 1'b0);
      end else begin
        cur = int'($urandom_range(0, N - 1));
        drive(jc(cur), 1'b0);
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/johnson_monitor.md
Name: johnson_monitor

Overview:
Receiving end of the Johnson-code counter interface.
- Watches a WIDTH-bit Johnson code bus (for example, a down counter's `signal` output) and decodes it to a binary index.
- Tracks step direction, flags illegal codes and out-of-sequence jumps, and keeps a saturating error count.
- Sits beside a Johnson counter as a checker and binary converter for downstream display and test logic.

Parameters:
WIDTH, 4, Johnson code width. Must be >= 2. Sequence length is 2*WIDTH.
CNT_W, 8, width of the saturating error counter.
STALL_CYCLES, 16, number of consecutive identical legal samples that assert `stall`. Used only when STALL_DETECT_EN is defined.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
code  in  WIDTH  Johnson code under observation; sampled every posedge.
value  out  IDXW  decoded index, 0..2*WIDTH-1, where IDXW = $clog2(2*WIDTH).
legal  out  1  last sample was a legal Johnson code.
dir_up  out  1  one-cycle pulse: last step was +1 (mod 2*WIDTH).
dir_down  out  1  one-cycle pulse: last step was -1 (mod 2*WIDTH).
wrap  out  1  one-cycle pulse on a step from 2W-1 to 0 (up) or from 0 to 2W-1 (down).
step_err  out  1  one-cycle pulse on an illegal code or a legal non-adjacent jump.
err_cnt  out  CNT_W  saturating error count.
stall  out  1  (STALL_DETECT_EN only) code held too long.

Behaviour:
- Index mapping (WIDTH=4):
  - 0 = 0000, 1 = 0001, 2 = 0011, 3 = 0111, 4 = 1111, 5 = 1110, 6 = 1100, 7 = 1000.
  - General rule: index k < W has its low k bits set; index k >= W has its high 2W-k bits set.
  - Any other pattern is illegal.
- Timing: decode is combinational on `code`; all outputs are registered. Latency is 1 cycle, so outputs after posedge n reflect `code` sampled at posedge n.
- Reset (synchronous, overrides all):
  - state = ACQ, prev_idx = 0.
  - value = 0, legal = 0, dir_up = 0, dir_down = 0, wrap = 0, step_err = 0, err_cnt = 0, stall = 0.
- FSM states: ACQ, TRACK, FAULT.
- ACQ:
  - Legal code: go to TRACK; value = prev_idx = idx; legal = 1; no direction or wrap pulse.
  - Illegal code: stay in ACQ; legal = 0; step_err = 1; err_cnt += 1.
- TRACK, legal code:
  - idx == prev: hold. No pulses.
  - idx == prev+1 mod 2W: dir_up = 1. wrap = 1 if prev == 2W-1.
  - idx == prev-1 mod 2W: dir_down = 1. wrap = 1 if prev == 0.
  - Any other legal idx: step_err = 1, err_cnt += 1, resync prev = idx, no direction pulse, stay in TRACK.
  - In every legal case: value = idx, legal = 1.
- TRACK, illegal code: step_err = 1, err_cnt += 1, legal = 0, value holds last legal idx, go to FAULT.
- FAULT:
  - Illegal code: stay; step_err = 1 and err_cnt += 1 on every illegal cycle.
  - Legal code: go to TRACK; resync value = prev = idx; no direction pulse.
- err_cnt saturates at all-ones and never wraps.
- dir_up, dir_down, wrap and step_err are never sticky. dir_up and dir_down are mutually exclusive.

Optional Feature:
STALL_DETECT_EN
- Defined:
  - A hold counter increments on each TRACK hold cycle and clears on any step, error, FSM exit, or reset.
  - `stall` = 1 while the count >= STALL_CYCLES-1, i.e. from the STALL_CYCLES-th identical sample onward.
  - `stall` deasserts on the next differing sample.
- Not defined: the `stall` port, the hold counter and STALL_CYCLES logic are all absent.

Decomposition:
- Package johnson_pkg holds:
  - state encodings ACQ/TRACK/FAULT;
  - IDXW derivation;
  - a function returning the code for an index, so the bench can generate stimulus from the same definition.
- One natural sub-module, johnson_code_decode: combinational, code -> {legal, idx}, parameterised by WIDTH.

Test Plan:
1. Reset, then code = 0000,1000,1100,1110,1111,0111,0011,0001,0000 -> value = 0,7,6,5,4,3,2,1,0; dir_down on every step after the first; wrap only on the 0->7 step; err_cnt = 0.
2. After acquiring at 0000, drive 0001,0011,...,1000,0000 -> value increments 1..7, then 0; dir_up on each step; wrap on 7->0.
3. In TRACK at 0011 (idx 2), drive 0101, then 0111 -> step_err = 1, legal = 0, value = 2, err_cnt = 1 (state FAULT); then value = 3, legal = 1, no dir pulse.
4. In TRACK at 0001 (idx 1), drive 1110 (idx 5) -> step_err = 1, err_cnt += 1, value = 5, no dir pulse; next 1100 gives dir_up = 1, value = 6.
5. CNT_W = 2: drive 5 consecutive illegal codes (1010) -> err_cnt = 1,2,3,3,3. Assert reset mid-stream -> all outputs 0 next cycle, state ACQ.
6. STALL_DETECT_EN defined, STALL_CYCLES = 4: hold 1100 for 6 cycles -> stall asserts at the 4th identical sample; next 1110 deasserts stall, dir_down = 1.
